// File: rtl/load_unit.sv
// load_unit -- sequences a single I-type load instruction.
//
// Walks IDLE -> ADDR -> REQ -> WB -> IDLE. In ADDR it reads rs from the
// register file and forms the effective address. In REQ it holds a word-aligned
// read request until the memory acknowledges. In WB it writes the extracted,
// extended value back to rt. Unsupported opcodes skip REQ and finish without
// a register write.
//
// Optional feature macro: LOAD_ALIGN_CHECK_EN
//   When defined, a 'misalign' output is added. A LW with EA[1:0] != 0, or a
//   LH/LHU with EA[0] != 0, skips REQ and completes with misalign=1 and no
//   register write. When undefined, the low address bits below the access size
//   are simply ignored.
//
// Ports:
//   clock                  rising-edge clock
//   reset                  asynchronous, active-low reset
//   start, instr           launch request and instruction word (taken in IDLE only)
//   busy, done             not-idle flag and one-cycle completion pulse
//   rf_raddr / rf_rdata    register-file read port (combinational read)
//   rf_we/waddr/wdata      register-file write port
//   mem_req/addr/ack/rdata data-memory read handshake
//   misalign               (LOAD_ALIGN_CHECK_EN only) misaligned-access flag in WB
module load_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef LOAD_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] data_q, data_d;
  logic        skip_q, skip_d;
`ifdef LOAD_ALIGN_CHECK_EN
  logic        mis_q, mis_d;
`endif

  logic [5:0]  opcode;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic [31:0] ea_calc;
  logic        op_valid;
  logic        misaligned_ea;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_value;

  assign opcode  = instr_q[31:26];
  assign rs      = instr_q[25:21];
  assign rt      = instr_q[20:16];
  assign imm     = instr_q[15:0];
  assign ea_calc = rf_rdata + {{16{imm[15]}}, imm};

  always_comb begin
    case (opcode)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_valid = 1'b1;
      default:                             op_valid = 1'b0;
    endcase
  end

`ifdef LOAD_ALIGN_CHECK_EN
  assign misaligned_ea = ((opcode == OP_LW) && (ea_calc[1:0] != 2'b00)) ||
                         (((opcode == OP_LH) || (opcode == OP_LHU)) && ea_calc[0]);
`else
  assign misaligned_ea = 1'b0;
`endif

  // skip_q marks a transaction that bypasses memory and must not write back
  // (unsupported opcode or misaligned access).
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ea_d    = ea_q;
    data_d  = data_q;
    skip_d  = skip_q;
`ifdef LOAD_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR;
          instr_d = instr;
          skip_d  = 1'b0;
`ifdef LOAD_ALIGN_CHECK_EN
          mis_d   = 1'b0;
`endif
        end
      end
      ST_ADDR: begin
        ea_d = ea_calc;
        if (!op_valid || misaligned_ea) begin
          state_d = ST_WB;
          skip_d  = 1'b1;
`ifdef LOAD_ALIGN_CHECK_EN
          mis_d   = misaligned_ea;
`endif
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = ST_WB;
        end
      end
      default: begin
        state_d = ST_IDLE;
`ifdef LOAD_ALIGN_CHECK_EN
        mis_d   = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      instr_q <= 32'h0;
      ea_q    <= 32'h0;
      data_q  <= 32'h0;
      skip_q  <= 1'b0;
`ifdef LOAD_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ea_q    <= ea_d;
      data_q  <= data_d;
      skip_q  <= skip_d;
`ifdef LOAD_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Big-endian lane selection: byte 0 is the most significant byte.
  always_comb begin
    case (ea_q[1:0])
      2'd0:    lane_byte = data_q[31:24];
      2'd1:    lane_byte = data_q[23:16];
      2'd2:    lane_byte = data_q[15:8];
      default: lane_byte = data_q[7:0];
    endcase
    lane_half = ea_q[1] ? data_q[15:0] : data_q[31:16];
    case (opcode)
      OP_LB:   load_value = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_value = {24'h0, lane_byte};
      OP_LH:   load_value = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_value = {16'h0, lane_half};
      OP_LW:   load_value = data_q;
      default: load_value = 32'h0;
    endcase
  end

  // Outputs are decoded from the registered state so that buses read as zero
  // outside the phase that owns them.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_WB);
    rf_raddr = (state_q == ST_ADDR) ? rs : 5'd0;
    mem_req  = (state_q == ST_REQ);
    mem_addr = (state_q == ST_REQ) ? {ea_q[31:2], 2'b00} : 32'h0;
    rf_we    = (state_q == ST_WB) && !skip_q && (rt != 5'd0);
    rf_waddr = (state_q == ST_WB) ? rt : 5'd0;
    rf_wdata = (state_q == ST_WB) ? load_value : 32'h0;
  end

`ifdef LOAD_ALIGN_CHECK_EN
  assign misalign = (state_q == ST_WB) && mis_q;
`endif

endmodule
